// File: rtl/cpu_pkg.sv
// Shared definitions for the Hack CPU: word widths, instruction field
// positions and the ALU control bundle carried in a C-instruction.
package cpu_pkg;

    // Data/instruction word width and address width, fixed by the Hack ISA.
    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 15;

    // Instruction bit positions.
    localparam int I_TYPE = 15;
    localparam int I_A    = 12;
    localparam int I_C_HI = 11;
    localparam int I_C_LO = 6;
    localparam int I_D1   = 5;
    localparam int I_D2   = 4;
    localparam int I_D3   = 3;
    localparam int I_J1   = 2;
    localparam int I_J2   = 1;
    localparam int I_J3   = 0;

    // ALU control bits in instruction order [11:6].
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

endpackage

// File: rtl/cpu_alu.sv
// Hack ALU: optional zero/negate of each operand, add or AND, optional
// negate of the result, plus zero and negative flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] x_z, x_n, y_z, y_n, res;

    // Operand conditioning, function select and output negation.
    // NOTE: every variable is assigned on every path through this block, so
    // no latch can be inferred.
    always_comb begin
        x_z = zx ? '0 : x;
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? '0 : y;
        y_n = ny ? ~y_z : y_z;
        res = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~res : res;
        zr  = (out == '0);
        ng  = out[WIDTH-1];
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle Hack CPU: holds A, D and pc, executes one instruction per
// clock and drives the data RAM through out_m / write_m / address_m.
module cpu
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_m,
    input  logic [WIDTH-1:0]      instruction,
    output logic [WIDTH-1:0]      out_m,
    output logic                  write_m,
    output logic [ADDR_WIDTH-1:0] address_m,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      d_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [WIDTH-1:0]      y_sel;
    logic [WIDTH-1:0]      alu_out;
    logic                  alu_zr;
    logic                  alu_ng;
    logic                  is_c;
    logic                  jump;
    alu_ctrl_t             ctrl;
    logic                  unused_bits;

    assign is_c        = instruction[I_TYPE];
    assign ctrl        = instruction[I_C_HI:I_C_LO];
    // Bits [14:13] of a C-instruction carry no meaning.
    assign unused_bits = ^instruction[14:13];

    // y operand: RAM value when the a-bit is set, otherwise A.
    assign y_sel = instruction[I_A] ? in_m : a_reg;

    cpu_alu u_alu (
        .x   (d_reg),
        .y   (y_sel),
        .zx  (ctrl.zx),
        .nx  (ctrl.nx),
        .zy  (ctrl.zy),
        .ny  (ctrl.ny),
        .f   (ctrl.f),
        .no  (ctrl.no),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign jump = is_c & ((instruction[I_J1] & alu_ng)
                        | (instruction[I_J2] & alu_zr)
                        | (instruction[I_J3] & ~alu_ng & ~alu_zr));

    // Next fetch address: reset wins, then a taken jump to the old A, else
    // sequential with natural wrap at the top of the address space.
    always_comb begin
        pc_next = pc_reg + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (reset) begin
            pc_next = '0;
        end else if (jump) begin
            pc_next = a_reg[ADDR_WIDTH-1:0];
        end
    end

    // Architectural state: A, D and pc, cleared synchronously on reset.
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values; a jump therefore sees the old A even when A is also written.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
        end else begin
            if (!is_c) begin
                a_reg <= instruction;
            end else if (instruction[I_D1]) begin
                a_reg <= alu_out;
            end
            if (is_c && instruction[I_D2]) begin
                d_reg <= alu_out;
            end
            pc_reg <= pc_next;
        end
    end

    assign out_m     = alu_out;
    assign write_m   = is_c & instruction[I_D3] & ~reset;
    assign address_m = a_reg[ADDR_WIDTH-1:0];
    assign pc        = pc_reg;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the Hack CPU: directed programs with literal
// expectations, then randomized instructions against a mnemonic-level model.
module tb_cpu;

    logic        clk;
    logic        reset;
    logic [15:0] in_m;
    logic [15:0] instruction;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;
    logic [14:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    logic [15:0] ma, md;
    logic [14:0] mpc;
    bit          model_valid = 0;

    // DUT outputs sampled in the middle of the last stepped cycle.
    logic [15:0] cyc_out;
    logic        cyc_w;
    logic [14:0] cyc_addr;

    // The 18 standard comp codes (c1..c6), used for random C-instructions.
    logic [5:0] comp_codes [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    cpu dut (
        .clk         (clk),
        .reset       (reset),
        .in_m        (in_m),
        .instruction (instruction),
        .out_m       (out_m),
        .write_m     (write_m),
        .address_m   (address_m),
        .pc          (pc)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hack comp table by mnemonic; y stands for A or M.
    function automatic logic [15:0] comp(input logic [5:0] c, input logic [15:0] d, input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return d;
            6'b110000: return y;
            6'b001101: return ~d;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - d;
            6'b110011: return 16'd0 - y;
            6'b011111: return d + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return d - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return d + y;
            6'b010011: return d - y;
            6'b000111: return y - d;
            6'b000000: return d & y;
            6'b010101: return d | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    // Apply one instruction for one clock: compare outputs mid-cycle against
    // the model, then let the edge happen and advance the model.
    task automatic step(input logic [15:0] ins, input logic [15:0] m, input logic rst);
        logic [15:0] v;
        logic        c_ins, lt, eq, gt, jmp;
        logic [15:0] old_a;
        instruction = ins;
        in_m        = m;
        reset       = rst;
        #1;
        cyc_out  = out_m;
        cyc_w    = write_m;
        cyc_addr = address_m;
        c_ins    = ins[15];
        check("write_m", {15'd0, write_m}, {15'd0, c_ins & ins[3] & ~rst});
        v = comp(ins[11:6], md, ins[12] ? m : ma);
        if (model_valid) begin
            check("address_m", {1'b0, address_m}, {1'b0, ma[14:0]});
            check("pc", {1'b0, pc}, {1'b0, mpc});
            if (c_ins) check("out_m", out_m, v);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            ma = 16'd0; md = 16'd0; mpc = 15'd0;
            model_valid = 1;
        end else if (model_valid) begin
            old_a = ma;
            lt  = $signed(v) < 0;
            eq  = (v == 16'd0);
            gt  = $signed(v) > 0;
            jmp = c_ins && ((ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt));
            if (!c_ins) ma = ins;
            else begin
                if (ins[5]) ma = v;
                if (ins[4]) md = v;
            end
            mpc = jmp ? old_a[14:0] : mpc + 15'd1;
        end
    endtask

    initial begin
        logic [14:0] pc_before;
        logic [15:0] ins, m;
        logic        r;
        reset = 1; instruction = 16'hFFFF; in_m = 16'd0;
        @(negedge clk);

        // Reset
        step(16'hFFFF, 16'd0, 1);
        check("reset write_m", {15'd0, cyc_w}, 16'd0);
        check("reset pc", {1'b0, pc}, 16'd0);
        check("reset address_m", {1'b0, address_m}, 16'd0);

        // A and D load
        step(16'h0005, 16'd0, 0);
        check("@5 address_m", {1'b0, address_m}, 16'd5);
        check("@5 pc", {1'b0, pc}, 16'd1);
        step(16'hEC10, 16'd0, 0);
        check("D=A out_m", cyc_out, 16'd5);
        check("D=A write_m", {15'd0, cyc_w}, 16'd0);
        check("D=A pc", {1'b0, pc}, 16'd2);

        // Memory write
        step(16'd100, 16'd0, 0);
        step(16'hE7C8, 16'd0, 0);
        check("M=D+1 out_m", cyc_out, 16'd6);
        check("M=D+1 write_m", {15'd0, cyc_w}, 16'd1);
        check("M=D+1 address_m", {1'b0, cyc_addr}, 16'd100);
        check("M=D+1 A kept", {1'b0, address_m}, 16'd100);

        // in_m path
        step(16'hFC10, 16'd7, 0);
        check("D=M out_m", cyc_out, 16'd7);
        step(16'hFCB8, 16'd7, 0);
        check("AMD=M-1 out_m", cyc_out, 16'd6);
        check("AMD=M-1 write_m", {15'd0, cyc_w}, 16'd1);
        check("AMD=M-1 address_m", {1'b0, cyc_addr}, 16'd100);
        check("AMD=M-1 new A", {1'b0, address_m}, 16'd6);
        step(16'hE300, 16'd0, 0);
        check("AMD=M-1 new D", cyc_out, 16'd6);

        // Jumps
        step(16'd42, 16'd0, 0);
        step(16'hEA90, 16'd0, 0);
        step(16'hE302, 16'd0, 0);
        check("JEQ taken pc", {1'b0, pc}, 16'd42);
        step(16'hEFD0, 16'd0, 0);
        pc_before = pc;
        step(16'hE302, 16'd0, 0);
        check("JEQ not taken pc", {1'b0, pc}, {1'b0, pc_before + 15'd1});
        step(16'hEE90, 16'd0, 0);
        step(16'd42, 16'd0, 0);
        step(16'hE304, 16'd0, 0);
        check("JLT taken pc", {1'b0, pc}, 16'd42);
        step(16'hEA87, 16'd0, 0);
        check("0;JMP pc", {1'b0, pc}, 16'd42);
        step(16'd7, 16'd0, 0);
        step(16'hE32F, 16'd0, 0);
        check("AM=D;JMP old A pc", {1'b0, pc}, 16'd7);
        check("AM=D;JMP new A", {1'b0, address_m}, 16'h7FFF);

        // pc wrap
        step(16'h7FFF, 16'd0, 0);
        step(16'hEA87, 16'd0, 0);
        check("jump to top pc", {1'b0, pc}, 16'h7FFF);
        step(16'hE300, 16'd0, 0);
        check("pc wrap", {1'b0, pc}, 16'd0);

        // Reset during M=D;JMP (D is 0xFFFF here)
        step(16'h0033, 16'd0, 0);
        step(16'hE30F, 16'd0, 1);
        check("reset abort write_m", {15'd0, cyc_w}, 16'd0);
        check("reset abort pc", {1'b0, pc}, 16'd0);
        check("reset abort A", {1'b0, address_m}, 16'd0);
        step(16'hE300, 16'd0, 0);
        check("reset abort D", cyc_out, 16'd0);

        // Randomized instruction stream
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                ins = $urandom_range(0, 1) ? {1'b0, 15'($urandom)} : {1'b0, 15'($urandom_range(0, 20))};
            end else begin
                ins = {1'b1, 2'($urandom), 1'($urandom), comp_codes[$urandom_range(0, 17)],
                       3'($urandom), 3'($urandom)};
            end
            case ($urandom_range(0, 3))
                0:       m = 16'd0;
                1:       m = 16'hFFFF;
                2:       m = 16'h8000;
                default: m = 16'($urandom);
            endcase
            r = ($urandom_range(0, 49) == 0);
            step(ins, m, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
